hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the `stall` (bubble) input of the ID/EX register, plus the PC, IF/ID and global hold controls of the 5-stage core.
- It consumes the EX-side outputs of the ID/EX register (`Rd_out`, `WB_sel_out`, `Reg_WB_out`), the decoded ID-stage sources, the EX branch resolution and the data-memory busy flag.
- From these it generates load-use bubbles, branch flushes and memory-wait freezes.
- It also keeps saturating performance counters for stall cycles and redirects.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID is squashed per taken redirect (≥1; >1 covers multi-cycle fetch latency)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high; all state and counters cleared
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of the instruction in EX (ID/EX `Rd_out`)
- ex_reg_wb  in  1  EX instruction writes the register file (`Reg_WB_out`)
- ex_mem_read  in  1  EX instruction is a load (`WB_sel_out`=1)
- ex_branch_taken  in  1  EX resolved a taken branch or jump; PC mux selects target
- mem_busy  in  1  data memory not ready; MEM stage cannot complete
- clr_counts  in  1  synchronous clear of both counters
- pc_we  out  1  PC register write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_bubble  out  1  to ID/EX `stall`; inserts a NOP
- pipe_hold  out  1  freeze IF/ID, ID/EX, EX/MEM, MEM/WB
- state  out  2  FSM state: RUN=0, FLUSH=2, MEM_WAIT=3 (1 reserved)
- stall_count  out  CNT_W  cycles with bubble or hold asserted, saturating
- flush_count  out  CNT_W  redirect events, saturating

Behaviour:
- Control outputs are combinational from the FSM state and current inputs. State and counters update on the rising clk edge.
- Reset values: state=RUN, both counters 0. The outputs then follow RUN with quiet inputs: pc_we=1, if_id_we=1, others 0.
- Hazard terms:
  - lu = ex_mem_read & ex_reg_wb & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - x0 never hazards.
- Priority per cycle: mem_busy > ex_branch_taken > lu.
- Any state, mem_busy=1:
  - pipe_hold=1, pc_we=0, if_id_we=0, bubble=0, flush=0.
  - Next state MEM_WAIT; the FLUSH remaining count is kept.
- RUN, taken (no busy):
  - pc_we=1, if_id_flush=1, id_ex_bubble=1; flush_count+1.
  - FLUSH_CYCLES>1 → FLUSH with rem=FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, lu only:
  - pc_we=0, if_id_we=0, id_ex_bubble=1 for exactly one cycle.
  - The bubble clears ex_rd next cycle, so no FSM state is needed.
- FLUSH:
  - if_id_flush=1, pc_we=1, bubble=0; rem-1 each cycle; rem reaching 0 → RUN.
  - A new taken branch here restarts rem and counts again.
- MEM_WAIT: on mem_busy=0, return to FLUSH if rem>0, else RUN. Control that cycle is evaluated as the target state.
- Branch held during hold: the held EX taken branch is acted on only in the first non-hold cycle, exactly once. Redirect is suppressed while pipe_hold=1.
- stall_count: +1 on any cycle with id_ex_bubble|pipe_hold, excluding bubbles caused by taken branches.
- Counters saturate at 2^CNT_W-1 with no wrap.
- clr_counts: forces both counters to 0 next edge; it wins over a simultaneous increment.
- Reset asserted mid-operation: state and counters clear immediately; outputs take RUN values while reset is held.

Decomposition:
- Shared package `core_pkg`:
  - state encoding constants ST_RUN/ST_FLUSH/ST_MEM_WAIT
  - REG_ZERO=5'd0
- Sub-module `sat_counter` (CNT_W, inc, clr) instantiated twice.
- Hazard compare and FSM stay in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_wb=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle of id_ex_bubble=1, pc_we=0, if_id_we=0; stall_count=1. Same stimulus with ex_rd=0 → no bubble.
- Taken branch, FLUSH_CYCLES=1: ex_branch_taken pulse → if_id_flush=1 and id_ex_bubble=1 in the same cycle; flush_count=1; state stays 0.
- FLUSH_CYCLES=3: taken pulse → if_id_flush high 3 consecutive cycles, state 2 for 2 cycles, then 0.
- mem_busy held 4 cycles with ex_branch_taken=1 → pipe_hold=1 and pc_we=0 for 4 cycles, state=3. Next cycle: exactly one redirect, flush_count=1, stall_count=4.
- Saturation, CNT_W=4: 20 stall cycles → stall_count=15. clr_counts with simultaneous stall → 0.
- Async reset asserted inside FLUSH with rem=1 → state=0, counters=0 immediately; after release, normal RUN outputs.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline control slice.
package core_pkg;

  // Encoding 2'd1 is reserved and never entered.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next value: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch flushes, memory-wait freezes,
// plus saturating stall / redirect counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wb,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             clr_counts,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned   REM_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d, eff_state;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             rs1_hit, rs2_hit, lu, redirect;
  logic             stall_inc;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu       = ex_mem_read && ex_reg_wb && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
  assign redirect = !mem_busy && ex_branch_taken;

  // Leaving MEM_WAIT behaves as the state being returned to in that same cycle
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (rem_q != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  // State and remaining-flush register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state; rem is frozen while memory is busy
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (mem_busy) begin
      state_d = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        rem_d   = REM_INIT;
      end else begin
        state_d = ST_RUN;
        rem_d   = '0;
      end
    end else if (eff_state == ST_FLUSH) begin
      rem_d   = rem_q - REM_W'(1);
      state_d = (rem_q == REM_W'(1)) ? ST_RUN : ST_FLUSH;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Control outputs; RUN defaults while reset is held
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pipe_hold = 1'b1;
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (eff_state == ST_FLUSH) begin
        if_id_flush = 1'b1;
      end else if (lu) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  assign state     = state_q;
  // Branch bubbles are counted as redirects, not stalls
  assign stall_inc = pipe_hold || (id_ex_bubble && !redirect);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .clr  (clr_counts),
    .count(stall_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (redirect),
    .clr  (clr_counts),
    .count(flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share one stimulus stream and are
// compared each cycle against a cycle-level model of the control rules.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_reg_wb, ex_mem_read;
  logic       ex_branch_taken, mem_busy, clr_counts;

  logic        pc_we_a, we_a, fl_a, bub_a, hold_a;
  logic        pc_we_b, we_b, fl_b, bub_b, hold_b;
  logic        pc_we_c, we_c, fl_c, bub_c, hold_c;
  logic [1:0]  st_a, st_b, st_c;
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [3:0]  sc_c, fc_c;

  int o_pc[3], o_we[3], o_fl[3], o_bub[3], o_hold[3], o_st[3], o_sc[3], o_fc[3];

  int nvec = 0;
  int nerr = 0;

  // Model: squash cycles still owed, whether last cycle was a memory wait, counters
  int m_left[3], m_stall[3], m_flush[3];
  bit m_busy_prev[3];
  int e_pc, e_we, e_fl, e_bub, e_hold, e_st;
  bit lu_m;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wb(ex_reg_wb), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .clr_counts(clr_counts),
    .pc_we(pc_we_a), .if_id_we(we_a), .if_id_flush(fl_a), .id_ex_bubble(bub_a),
    .pipe_hold(hold_a), .state(st_a), .stall_count(sc_a), .flush_count(fc_a)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wb(ex_reg_wb), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .clr_counts(clr_counts),
    .pc_we(pc_we_b), .if_id_we(we_b), .if_id_flush(fl_b), .id_ex_bubble(bub_b),
    .pipe_hold(hold_b), .state(st_b), .stall_count(sc_b), .flush_count(fc_b)
  );

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wb(ex_reg_wb), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .clr_counts(clr_counts),
    .pc_we(pc_we_c), .if_id_we(we_c), .if_id_flush(fl_c), .id_ex_bubble(bub_c),
    .pipe_hold(hold_c), .state(st_c), .stall_count(sc_c), .flush_count(fc_c)
  );

  always_comb begin
    o_pc[0] = int'(pc_we_a); o_we[0] = int'(we_a); o_fl[0] = int'(fl_a);
    o_bub[0] = int'(bub_a); o_hold[0] = int'(hold_a); o_st[0] = int'(st_a);
    o_sc[0] = int'(sc_a); o_fc[0] = int'(fc_a);
    o_pc[1] = int'(pc_we_b); o_we[1] = int'(we_b); o_fl[1] = int'(fl_b);
    o_bub[1] = int'(bub_b); o_hold[1] = int'(hold_b); o_st[1] = int'(st_b);
    o_sc[1] = int'(sc_b); o_fc[1] = int'(fc_b);
    o_pc[2] = int'(pc_we_c); o_we[2] = int'(we_c); o_fl[2] = int'(fl_c);
    o_bub[2] = int'(bub_c); o_hold[2] = int'(hold_c); o_st[2] = int'(st_c);
    o_sc[2] = int'(sc_c); o_fc[2] = int'(fc_c);
  end

  function automatic int fc_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic int max_of(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model to the next edge
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        chk("rst_pc_we", i, o_pc[i], 1);
        chk("rst_if_id_we", i, o_we[i], 1);
        chk("rst_flush", i, o_fl[i], 0);
        chk("rst_bubble", i, o_bub[i], 0);
        chk("rst_hold", i, o_hold[i], 0);
        chk("rst_state", i, o_st[i], 0);
        m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_busy_prev[i] = 1'b0;
      end
    end else begin
      lu_m = ex_mem_read && ex_reg_wb && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      for (int i = 0; i < 3; i++) begin
        e_pc = 1; e_we = 1; e_fl = 0; e_bub = 0; e_hold = 0;
        if (mem_busy) begin
          e_hold = 1; e_pc = 0; e_we = 0;
        end else if (ex_branch_taken) begin
          e_fl = 1; e_bub = 1;
        end else if (m_left[i] > 0) begin
          e_fl = 1;
        end else if (lu_m) begin
          e_pc = 0; e_we = 0; e_bub = 1;
        end
        e_st = m_busy_prev[i] ? 3 : (m_left[i] > 0 ? 2 : 0);
        chk("pc_we", i, o_pc[i], e_pc);
        chk("if_id_we", i, o_we[i], e_we);
        chk("if_id_flush", i, o_fl[i], e_fl);
        chk("id_ex_bubble", i, o_bub[i], e_bub);
        chk("pipe_hold", i, o_hold[i], e_hold);
        chk("state", i, o_st[i], e_st);
        chk("stall_count", i, o_sc[i], m_stall[i]);
        chk("flush_count", i, o_fc[i], m_flush[i]);
        // advance
        m_busy_prev[i] = mem_busy;
        if (mem_busy) begin
          if (m_stall[i] < max_of(i)) m_stall[i]++;
        end else if (ex_branch_taken) begin
          m_left[i] = fc_of(i) - 1;
          if (m_flush[i] < max_of(i)) m_flush[i]++;
        end else if (m_left[i] > 0) begin
          m_left[i]--;
        end else if (lu_m) begin
          if (m_stall[i] < max_of(i)) m_stall[i]++;
        end
        if (clr_counts) begin
          m_stall[i] = 0; m_flush[i] = 0;
        end
      end
    end
  end

  task automatic quiet();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_reg_wb = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0; clr_counts = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    settle();
    chk("lit_reset_pc_we", 0, o_pc[0], 1);
    chk("lit_reset_state", 0, o_st[0], 0);
    chk("lit_reset_stall", 0, o_sc[0], 0);
    step();
    reset = 1'b0;

    // Load-use on rs1, then the same with x0
    ex_mem_read = 1'b1; ex_reg_wb = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    settle();
    chk("lit_lu_bubble", 0, o_bub[0], 1);
    chk("lit_lu_pc_we", 0, o_pc[0], 0);
    chk("lit_lu_if_id_we", 0, o_we[0], 0);
    step();
    quiet();
    chk("lit_lu_stall_count", 0, o_sc[0], 1);
    ex_mem_read = 1'b1; ex_reg_wb = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    settle();
    chk("lit_x0_bubble", 0, o_bub[0], 0);
    chk("lit_x0_pc_we", 0, o_pc[0], 1);
    step();
    quiet();

    // Taken branch: single-cycle squash on a, three-cycle squash on b
    do_reset();
    ex_branch_taken = 1'b1;
    settle();
    chk("lit_br_flush", 0, o_fl[0], 1);
    chk("lit_br_bubble", 0, o_bub[0], 1);
    chk("lit_br_flush_b", 1, o_fl[1], 1);
    step();
    ex_branch_taken = 1'b0;
    chk("lit_br_flush_count", 0, o_fc[0], 1);
    chk("lit_br_state", 0, o_st[0], 0);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("lit_fl3_state", 1, o_st[1], 2);
      chk("lit_fl3_flush", 1, o_fl[1], 1);
      step();
    end
    settle();
    chk("lit_fl3_end_state", 1, o_st[1], 0);
    chk("lit_fl3_end_flush", 1, o_fl[1], 0);
    step();

    // Memory wait with a held taken branch
    do_reset();
    mem_busy = 1'b1; ex_branch_taken = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("lit_mw_hold", 0, o_hold[0], 1);
      chk("lit_mw_pc_we", 0, o_pc[0], 0);
      step();
      chk("lit_mw_state", 0, o_st[0], 3);
    end
    mem_busy = 1'b0;
    settle();
    chk("lit_mw_redirect", 0, o_fl[0], 1);
    step();
    ex_branch_taken = 1'b0;
    chk("lit_mw_flush_count", 0, o_fc[0], 1);
    chk("lit_mw_stall_count", 0, o_sc[0], 4);

    // Saturation on the 4-bit instance and clear-wins
    do_reset();
    mem_busy = 1'b1;
    repeat (20) step();
    chk("lit_sat_c", 2, o_sc[2], 15);
    chk("lit_sat_a", 0, o_sc[0], 20);
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0; mem_busy = 1'b0;
    chk("lit_clr_c", 2, o_sc[2], 0);
    chk("lit_clr_a", 0, o_sc[0], 0);

    // Async reset inside FLUSH with one squash cycle left
    do_reset();
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    step();
    chk("lit_ar_pre_state", 1, o_st[1], 2);
    #2 reset = 1'b1;
    #1;
    chk("lit_ar_state", 1, o_st[1], 0);
    chk("lit_ar_flush_count", 1, o_fc[1], 0);
    settle();
    chk("lit_ar_hold_pc_we", 1, o_pc[1], 1);
    chk("lit_ar_hold_flush", 1, o_fl[1], 0);
    step();
    reset = 1'b0;
    settle();
    chk("lit_ar_post_pc_we", 1, o_pc[1], 1);
    chk("lit_ar_post_if_id_we", 1, o_we[1], 1);
    chk("lit_ar_post_state", 1, o_st[1], 0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = ($urandom_range(0, 3) != 0);
      id_use_rs2      = ($urandom_range(0, 1) != 0);
      ex_reg_wb       = ($urandom_range(0, 3) != 0);
      ex_mem_read     = ($urandom_range(0, 1) != 0);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_busy        = ($urandom_range(0, 4) == 0);
      clr_counts      = ($urandom_range(0, 39) == 0);
      reset           = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    quiet();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
